disp_pingpong_scanout: RTL and testbench

- Parametrised successor to the fixed two-buffer display datapath.
- Pixels are written into one of two line buffers (ping-pong) over a valid/ready handshake. Meanwhile the other buffer is scanned out under an internal pixel/line timing generator with horizontal and vertical blanking.
- Generalised in resolution, blanking, channel count and channel width. Adds backpressure, underflow detection and frame-start signalling.
- Sits between the host write path (CSDisplay/WData side) and the panel/frame sink.

---
 rtl/disp_pingpong_scanout.sv | 162 ++++++++++++++++
 tb/tb_disp_pingpong_scanout.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_pingpong_scanout.sv
// disp_pingpong_scanout: ping-pong line buffers written over valid/ready, scanned out under a raster timing generator
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   cs_display            scan enable; low freezes the raster counters
//   wr_valid, wr_data     host pixel write; wr_ready is combinational from buffer state
//   pix_out, de, hblank, vblank, frame_start, underflow
//                         registered scan outputs, one cycle after the counter state
//   buf_full[1:0]         per-buffer FULL/DRAINING status
//   underflow_cnt[15:0]   saturating underflow count, present only with DISP_UNDERFLOW_CNT_EN
module disp_pingpong_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int PIX_W    = 8,
  parameter int NCH      = 3,
  parameter logic [NCH*PIX_W-1:0] BLANK_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_display,
  input  logic                 wr_valid,
  input  logic [NCH*PIX_W-1:0] wr_data,
  output logic                 wr_ready,
  output logic [NCH*PIX_W-1:0] pix_out,
  output logic                 de,
  output logic                 hblank,
  output logic                 vblank,
  output logic                 frame_start,
  output logic                 underflow,
`ifdef DISP_UNDERFLOW_CNT_EN
  output logic [15:0]          underflow_cnt,
`endif
  output logic [1:0]           buf_full
);
  localparam int DW    = NCH * PIX_W;
  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_ACTIVE + V_BLANK;
  localparam int CW    = $clog2(H_TOT);
  localparam int LW    = $clog2(V_TOT);
  localparam int AW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [CW-1:0] PX_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] PX_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LN_LAST     = LW'(V_TOT - 1);
  localparam logic [AW-1:0] A_LAST      = AW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_state_e;

  logic [CW-1:0] px_cnt_q, px_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic          line_ok_q, line_ok_d;
  buf_state_e    bst_q [2];
  buf_state_e    bst_d [2];
  logic [DW-1:0] pix_out_q, pix_out_d;
  logic          de_q, de_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;
  logic          underflow_q, underflow_d;
  logic [DW-1:0] mem_q [2][H_ACTIVE];

  logic          h_act, v_act, px_wrap, line_start, rd_ok, line_end;
  logic          wr_fire, wr_last;
  logic [AW-1:0] rd_addr;

  assign h_act      = int'(px_cnt_q) < H_ACTIVE;
  assign v_act      = int'(line_cnt_q) < V_ACTIVE;
  assign px_wrap    = px_cnt_q == PX_LAST;
  assign line_start = cs_display && v_act && px_cnt_q == '0;
  // only a buffer already FULL before this edge can start a line, so a
  // buffer completing on the line-start cycle waits for the next line
  assign rd_ok      = line_start ? bst_q[rsel_q] == FULL : line_ok_q;
  assign line_end   = cs_display && v_act && rd_ok && px_cnt_q == PX_ACT_LAST;
  assign rd_addr    = px_cnt_q[AW-1:0];
  assign wr_ready   = bst_q[wsel_q] == EMPTY || bst_q[wsel_q] == FILLING;
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_last    = waddr_q == A_LAST;

  always_comb begin
    px_cnt_d      = cs_display ? (px_wrap ? '0 : px_cnt_q + 1'b1) : px_cnt_q;
    line_cnt_d    = (cs_display && px_wrap) ? (line_cnt_q == LN_LAST ? '0 : line_cnt_q + 1'b1) : line_cnt_q;
    rsel_d        = rsel_q ^ line_end;
    line_ok_d     = rd_ok && !line_end;
    wsel_d        = wsel_q ^ (wr_fire && wr_last);
    waddr_d       = wr_fire ? (wr_last ? '0 : waddr_q + 1'b1) : waddr_q;
    bst_d         = bst_q;
    // read and write never touch the same buffer: the writer owns EMPTY/FILLING,
    // the reader owns FULL/DRAINING
    if (line_start && rd_ok) bst_d[rsel_q] = DRAINING;
    if (line_end) bst_d[rsel_q] = EMPTY;
    if (wr_fire) bst_d[wsel_q] = wr_last ? FULL : FILLING;
    de_d          = cs_display && h_act && v_act;
    hblank_d      = !h_act;
    vblank_d      = !v_act;
    frame_start_d = cs_display && px_cnt_q == '0 && line_cnt_q == '0;
    underflow_d   = line_start && !rd_ok;
    pix_out_d     = !de_d ? '0 : rd_ok ? mem_q[rsel_q][rd_addr] : BLANK_COLOR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_cnt_q      <= '0;
      line_cnt_q    <= '0;
      waddr_q       <= '0;
      wsel_q        <= 1'b0;
      rsel_q        <= 1'b0;
      line_ok_q     <= 1'b0;
      bst_q         <= '{EMPTY, EMPTY};
      pix_out_q     <= '0;
      de_q          <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      px_cnt_q      <= px_cnt_d;
      line_cnt_q    <= line_cnt_d;
      waddr_q       <= waddr_d;
      wsel_q        <= wsel_d;
      rsel_q        <= rsel_d;
      line_ok_q     <= line_ok_d;
      bst_q         <= bst_d;
      pix_out_q     <= pix_out_d;
      de_q          <= de_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  // line storage carries no reset: buffer state alone decides validity
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wsel_q][waddr_q] <= wr_data;
  end

`ifdef DISP_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_q, underflow_cnt_d;

  always_comb begin
    underflow_cnt_d = (underflow_d && underflow_cnt_q != 16'hFFFF) ? underflow_cnt_q + 16'd1 : underflow_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) underflow_cnt_q <= '0;
    else underflow_cnt_q <= underflow_cnt_d;
  end

  assign underflow_cnt = underflow_cnt_q;
`endif

  assign pix_out     = pix_out_q;
  assign de          = de_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign buf_full    = {bst_q[1] == FULL || bst_q[1] == DRAINING, bst_q[0] == FULL || bst_q[0] == DRAINING};
endmodule

// File: tb/tb_disp_pingpong_scanout.sv
// tb_disp_pingpong_scanout: directed bench with a line-queue reference model for disp_pingpong_scanout
module tb_disp_pingpong_scanout;
  localparam int HA = 8, HB = 4, VA = 4, VB = 2;

  logic        clk, reset, cs_display, wr_valid, wr_ready;
  logic [23:0] wr_data, pix_out;
  logic        de, hblank, vblank, frame_start, underflow;
  logic [1:0]  buf_full;
`ifdef DISP_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  disp_pingpong_scanout #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .PIX_W(8), .NCH(3), .BLANK_COLOR(24'h0)
  ) dut (
    .clk(clk), .reset(reset), .cs_display(cs_display), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .pix_out(pix_out), .de(de), .hblank(hblank), .vblank(vblank),
    .frame_start(frame_start), .underflow(underflow),
`ifdef DISP_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .buf_full(buf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of complete lines (at most two held, counting the
  // one being shown) plus a raster position; expectations follow the
  // registered outputs one edge after the raster state they describe.
  typedef logic [HA*24-1:0] line_t;
  line_t       lines[$];
  line_t       fill, drain;
  int          fill_n = 0, mpx = 0, mline = 0, mr = 0;
  bit          mdrain = 0;
  logic [23:0] e_pix = 0;
  logic        e_de = 0, e_hb = 0, e_vb = 0, e_fs = 0, e_uf = 0;
  int          e_ucnt = 0;

  function automatic bit m_ready();
    return (lines.size() + int'(mdrain)) < 2;
  endfunction

  function automatic logic [1:0] m_bf();
    int n;
    logic [1:0] b;
    n = lines.size() + int'(mdrain);
    b = 2'b00;
    if (n >= 1) b[mr] = 1'b1;
    if (n >= 2) b[mr ^ 1] = 1'b1;
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mpx = 0; mline = 0; mr = 0; mdrain = 0; fill_n = 0;
      lines.delete();
      e_pix = 0; e_de = 0; e_hb = 0; e_vb = 0; e_fs = 0; e_uf = 0; e_ucnt = 0;
    end else begin : step
      bit rdy;
      rdy = m_ready();
      e_de = cs_display && mpx < HA && mline < VA;
      e_hb = mpx >= HA;
      e_vb = mline >= VA;
      e_fs = cs_display && mpx == 0 && mline == 0;
      e_uf = 0;
      if (cs_display && mline < VA && mpx == 0) begin
        if (lines.size() > 0) begin
          drain = lines.pop_front();
          mdrain = 1;
        end else e_uf = 1;
      end
      e_pix = !e_de ? 24'h0 : mdrain ? drain[mpx*24 +: 24] : 24'h0;
      if (cs_display && mdrain && mpx == HA - 1) begin
        mdrain = 0;
        mr = mr ^ 1;
      end
      if (e_uf && e_ucnt < 65535) e_ucnt++;
      if (wr_valid && rdy) begin
        fill[fill_n*24 +: 24] = wr_data;
        fill_n++;
        if (fill_n == HA) begin
          lines.push_back(fill);
          fill_n = 0;
        end
      end
      if (cs_display) begin
        mpx++;
        if (mpx == HA + HB) begin
          mpx = 0;
          mline = (mline + 1) % (VA + VB);
        end
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  initial forever begin
    logic [63:0] got, exp;
    @(posedge clk);
    #2;
    got = {32'h0, pix_out, de, hblank, vblank, frame_start, underflow, wr_ready, buf_full};
    exp = {32'h0, e_pix, e_de, e_hb, e_vb, e_fs, e_uf, m_ready(), m_bf()};
`ifdef DISP_UNDERFLOW_CNT_EN
    got[47:32] = underflow_cnt;
    exp[47:32] = 16'(e_ucnt);
`endif
    chk($sformatf("model_cmp@%0t", $time), got, exp);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int uf_n, de_n, hb_n, nz, fs_n, fs_at2, acc, n;
    logic pd;
    reset = 1'b0; cs_display = 1'b0; wr_valid = 1'b0; wr_data = 24'h0;
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_outs", {pix_out, de, hblank, vblank, frame_start, underflow}, 0);

    // no writes: first line underflows with blank pixels, frames every 72 cycles
    reset = 1'b1; cs_display = 1'b1;
    uf_n = 0; de_n = 0; hb_n = 0; nz = 0; fs_n = 0; fs_at2 = -1;
    for (int i = 0; i < 146; i++) begin
      @(negedge clk);
      if (i < 12) begin
        uf_n += int'(underflow); de_n += int'(de); hb_n += int'(hblank);
        if (de && pix_out != 0) nz++;
      end
      if (frame_start) begin
        fs_n++;
        if (fs_n == 2) fs_at2 = i;
      end
    end
    chk("a_underflow_cnt", uf_n, 1);
    chk("a_de_cycles", de_n, 8);
    chk("a_hblank_cycles", hb_n, 4);
    chk("a_nonzero_pix", nz, 0);
    chk("a_fs_count", fs_n, 3);
    chk("a_fs_period", fs_at2, 72);

    // one full line written, then shown at the next line start
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1; wr_data = 24'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    pd = de; n = 0;
    @(negedge clk);
    while (!(de && !pd && !underflow) && n < 300) begin
      pd = de;
      @(negedge clk);
      n++;
    end
    chk("b_line_start", {de, underflow}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b_pix%0d", k), pix_out, k + 1);
      if (k == 0) chk("b_bf_drain", buf_full, 2'b01);
    end
    chk("b_bf_done", buf_full, 2'b00);

    // scan frozen: writer fills both buffers then stalls
    cs_display = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = 24'h100 + 24'(acc);
      if (wr_ready) acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("c_transfers", acc, 16);
    chk("c_wr_ready", wr_ready, 0);
    chk("c_buf_full", buf_full, 2'b11);
    chk("c_frozen", {de, frame_start, underflow}, 0);

    // resume: two consecutive lines drain both buffers in fill order
    cs_display = 1'b1; n = 0;
    while (de !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("d_line1_start", {de, underflow}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("d1_pix%0d", k), pix_out, 24'h100 + 24'(k));
      if (k == 6) chk("d_ready_before", wr_ready, 0);
      if (k == 7) chk("d_ready_after", wr_ready, 1);
    end
    @(negedge clk); n = 0;
    while (de !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("d_line2_start", {de, underflow}, 2'b10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("d2_pix%0d", k), pix_out, 24'h108 + 24'(k));
    end

    // reset in the middle of the drain
    reset = 1'b0;
    #1;
    chk("e_rst_outs", {pix_out, de, hblank, vblank, frame_start, underflow}, 0);
    chk("e_rst_bf", buf_full, 2'b00);
    chk("e_rst_ready", wr_ready, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("e_post_rst_uf", {de, frame_start, underflow, pix_out}, {3'b111, 24'h0});

    // mixed enable and write traffic, checked only by the model
    for (int i = 0; i < 400; i++) begin
      cs_display = (i % 9) != 4;
      wr_valid = (i % 3) != 1;
      wr_data = 24'(i) * 24'h010203;
      @(negedge clk);
    end
    wr_valid = 1'b0; cs_display = 1'b1;

`ifdef DISP_UNDERFLOW_CNT_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (144) @(negedge clk);
    chk("f_underflow_cnt", underflow_cnt, 8);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
